regfile_2r1w: RTL and testbench

REGFILE_2R1W -- requirements
Module: regfile_2r1w

---
 rtl/regfile_2r1w.sv | 85 ++++++++
 tb/tb_regfile_2r1w.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with hardwired zero register, sticky ALU
// overflow flag and committed-write counter. Define REGFILE_BYPASS_EN for write-through reads.
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              ovf_in,
  input  logic              ovf_clr,
  output logic              ovf_sticky,
  output logic [7:0]        wr_cnt
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              write_hit;
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  assign write_hit = we && (wa != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[wa] <= wd;
    end
  end

  // Counter only sees writes that actually land in a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= 8'd0;
    end else if (write_hit) begin
      wr_cnt <= wr_cnt + 8'd1;
    end
  end

  // Set outranks clear; address 0 writes still report overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (we && ovf_in) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  always_comb begin
    stored1 = (ra1 == '0) ? '0 : regs[ra1];
    stored2 = (ra2 == '0) ? '0 : regs[ra2];
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!rst) begin
      rd1 = (write_hit && (ra1 == wa)) ? wd : stored1;
      rd2 = (write_hit && (ra2 == wa)) ? wd : stored2;
    end
  end
`else
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!rst) begin
      rd1 = stored1;
      rd2 = stored2;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w; expected values are hand-computed
// and adapt to REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_2r1w;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int AW     = 3;

  logic              clk;
  logic              rst;
  logic [AW-1:0]     ra1;
  logic [AW-1:0]     ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we;
  logic [AW-1:0]     wa;
  logic [DATA_W-1:0] wd;
  logic              ovf_in;
  logic              ovf_clr;
  logic              ovf_sticky;
  logic [7:0]        wr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .ovf_in(ovf_in), .ovf_clr(ovf_clr),
    .ovf_sticky(ovf_sticky), .wr_cnt(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of write-side inputs, let the edge happen, then idle them.
  task automatic applyStimulus(input logic w_en, input logic [AW-1:0] w_addr,
                               input logic [DATA_W-1:0] w_data,
                               input logic o_in, input logic o_clr);
    @(negedge clk);
    we = w_en; wa = w_addr; wd = w_data; ovf_in = o_in; ovf_clr = o_clr;
    @(posedge clk);
    #1;
    we = 1'b0; ovf_in = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic readPair(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ra1 = a1; ra2 = a2;
    #1;
  endtask

  initial begin
    rst = 1'b1; ra1 = '0; ra2 = '0; we = 1'b0; wa = '0; wd = '0;
    ovf_in = 1'b0; ovf_clr = 1'b0;
    #12;
    readPair(3'd3, 3'd5);
    checkOutput("reset_rd1", 32'(rd1), 32'h0);
    checkOutput("reset_ovf", 32'(ovf_sticky), 32'h0);
    checkOutput("reset_cnt", 32'(wr_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Zero register ignores writes and the counter stays put.
    applyStimulus(1'b1, 3'd0, 16'hBEEF, 1'b0, 1'b0);
    readPair(3'd0, 3'd0);
    checkOutput("zero_rd1", 32'(rd1), 32'h0);
    checkOutput("zero_cnt", 32'(wr_cnt), 32'h0);

    applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0);
    readPair(3'd3, 3'd3);
    checkOutput("wr3_rd1", 32'(rd1), 32'h1234);
    checkOutput("wr3_rd2", 32'(rd2), 32'h1234);
    checkOutput("wr3_cnt", 32'(wr_cnt), 32'h1);

    // Same-cycle read of the address being written.
    @(negedge clk);
    ra1 = 3'd3; ra2 = 3'd5; we = 1'b1; wa = 3'd5; wd = 16'hA5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_rd2", 32'(rd2), 32'hA5A5);
`else
    checkOutput("bypass_rd2", 32'(rd2), 32'h0);
`endif
    checkOutput("bypass_rd1_other", 32'(rd1), 32'h1234);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    checkOutput("after_wr5_rd2", 32'(rd2), 32'hA5A5);
    checkOutput("after_wr5_cnt", 32'(wr_cnt), 32'h2);

    // Sticky overflow sequence.
    applyStimulus(1'b1, 3'd0, 16'h0000, 1'b1, 1'b0);
    checkOutput("ovf_set_wa0", 32'(ovf_sticky), 32'h1);
    checkOutput("ovf_wa0_cnt", 32'(wr_cnt), 32'h2);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 3'd2, 16'(i), 1'b0, 1'b0);
    end
    checkOutput("ovf_hold", 32'(ovf_sticky), 32'h1);
    checkOutput("ovf_hold_cnt", 32'(wr_cnt), 32'h5);
    applyStimulus(1'b1, 3'd4, 16'h4444, 1'b1, 1'b1);
    checkOutput("ovf_set_wins", 32'(ovf_sticky), 32'h1);
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
    checkOutput("ovf_cleared", 32'(ovf_sticky), 32'h0);
    applyStimulus(1'b0, 3'd6, 16'hDEAD, 1'b1, 1'b0);
    checkOutput("ovf_ignored_we0", 32'(ovf_sticky), 32'h0);
    checkOutput("we0_cnt", 32'(wr_cnt), 32'h6);
    readPair(3'd2, 3'd4);
    checkOutput("reg2", 32'(rd1), 32'h3);
    checkOutput("reg4", 32'(rd2), 32'h4444);
    readPair(3'd6, 3'd6);
    checkOutput("reg6_untouched", 32'(rd1), 32'h0);

    // Short asynchronous reset pulse between edges, then counter wrap.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("pulse_cnt", 32'(wr_cnt), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b1, 3'd1, 16'(i), 1'b0, 1'b0);
    end
    checkOutput("cnt_255", 32'(wr_cnt), 32'hFF);
    applyStimulus(1'b1, 3'd1, 16'h00FF, 1'b0, 1'b0);
    checkOutput("cnt_wrap", 32'(wr_cnt), 32'h0);
    readPair(3'd1, 3'd1);
    checkOutput("reg1_last", 32'(rd1), 32'hFF);

    // Fill every register, flag an overflow, then reset mid-cycle.
    for (int i = 1; i < NREGS; i++) begin
      applyStimulus(1'b1, AW'(i), 16'(i), (i == NREGS - 1) ? 1'b1 : 1'b0, 1'b0);
    end
    readPair(3'd7, 3'd1);
    checkOutput("fill_rd1", 32'(rd1), 32'h7);
    checkOutput("fill_rd2", 32'(rd2), 32'h1);
    checkOutput("fill_ovf", 32'(ovf_sticky), 32'h1);
    checkOutput("fill_cnt", 32'(wr_cnt), 32'h7);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_rd1", 32'(rd1), 32'h0);
    checkOutput("mid_rst_rd2", 32'(rd2), 32'h0);
    checkOutput("mid_rst_ovf", 32'(ovf_sticky), 32'h0);
    checkOutput("mid_rst_cnt", 32'(wr_cnt), 32'h0);
    // A write attempted while reset is held must be lost.
    we = 1'b1; wa = 3'd3; wd = 16'hFFFF;
    #1;
    readPair(3'd3, 3'd3);
    checkOutput("rst_bypass_blocked", 32'(rd2), 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      readPair(AW'(i), AW'(i));
      checkOutput($sformatf("rst_reg%0d", i), 32'(rd1), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    readPair(3'd3, 3'd3);
    checkOutput("rst_write_lost", 32'(rd1), 32'h0);
    checkOutput("rst_write_cnt", 32'(wr_cnt), 32'h0);

    // First edge after release behaves normally.
    applyStimulus(1'b1, 3'd6, 16'h6666, 1'b0, 1'b0);
    readPair(3'd6, 3'd0);
    checkOutput("post_rst_wr", 32'(rd1), 32'h6666);
    checkOutput("post_rst_rd0", 32'(rd2), 32'h0);
    checkOutput("post_rst_cnt", 32'(wr_cnt), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
